pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage in-order core (IF, OF, EX, MA, RW). It tracks in-flight register writers in a shadow scoreboard and generates PC and pipeline-register enables, bubbles and flushes. It resolves three conditions: RAW hazards with no forwarding, taken branches resolved in EX, and multi-cycle div/mod occupancy of EX. It sits beside the datapath and drives the IF/OF and OF/EX pipeline registers, the PC register and the EX/MA hold.

---
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage in-order core: RAW interlock from a
// shadow writer scoreboard, taken-branch flush, and multi-cycle div/mod EX occupancy.
module pipe_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 8,
    parameter int unsigned NREG       = 16,
    localparam int unsigned RA        = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          of_valid,
    input  logic [RA-1:0] of_rs1,
    input  logic [RA-1:0] of_rs2,
    input  logic          of_rs1_used,
    input  logic          of_rs2_used,
    input  logic          of_wb,
    input  logic [RA-1:0] of_rd,
    input  logic          of_is_multi,
    input  logic          br_taken,
    output logic          pc_en,
    output logic          if_of_en,
    output logic          if_of_flush,
    output logic          of_ex_en,
    output logic          of_ex_bubble,
    output logic          ex_hold,
    output logic [15:0]   stall_cnt,
    output logic [15:0]   flush_cnt
);

    typedef enum logic {RUN, MULTI} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [7:0]           mcnt;

    // Scoreboard index 0 = EX, 1 = MA, 2 = RW
    logic [2:0]           sb_v;
    logic [2:0]           sb_wb;
    logic [2:0][RA-1:0]   sb_rd;

    logic                 match1;
    logic                 match2;
    logic                 raw;
    logic                 accept;
    logic                 go_multi;
    logic                 do_flush;
    logic                 do_stall;

    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int unsigned s = 0; s < 3; s++) begin
            if (sb_v[s] && sb_wb[s] && sb_rd[s] == of_rs1) match1 = 1'b1;
            if (sb_v[s] && sb_wb[s] && sb_rd[s] == of_rs2) match2 = 1'b1;
        end
    end

    assign raw = of_valid & ((of_rs1_used & match1) | (of_rs2_used & match2));

    // Output decode; reset gates everything combinationally
    always_comb begin
        pc_en        = 1'b0;
        if_of_en     = 1'b0;
        if_of_flush  = 1'b0;
        of_ex_en     = 1'b0;
        of_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        if (rst) begin
            if (state == MULTI) begin
                ex_hold = 1'b1;
            end else if (start) begin
                if (br_taken) begin
                    pc_en        = 1'b1;
                    if_of_en     = 1'b1;
                    if_of_flush  = 1'b1;
                    of_ex_en     = 1'b1;
                    of_ex_bubble = 1'b1;
                end else if (raw) begin
                    of_ex_en     = 1'b1;
                    of_ex_bubble = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    if_of_en = 1'b1;
                    of_ex_en = 1'b1;
                end
            end
        end
    end

    assign accept   = of_ex_en & ~of_ex_bubble;
    assign go_multi = accept & of_valid & of_is_multi & (DIV_CYCLES > 1);
    assign do_flush = start & (state == RUN) & br_taken;
    assign do_stall = start & (state == RUN) & ~br_taken & raw;

    always_comb begin
        state_nxt = state;
        if (start) begin
            case (state)
                RUN:     if (go_multi) state_nxt = MULTI;
                MULTI:   if (mcnt == 8'd1) state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt <= '0;
        end else if (start) begin
            if (state == RUN && go_multi) mcnt <= 8'(DIV_CYCLES - 1);
            else if (state == MULTI)      mcnt <= mcnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (do_flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
            if (do_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // In MULTI the divider stays in EX and a hole opens behind it in MA
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_v  <= '0;
            sb_wb <= '0;
            sb_rd <= '0;
        end else if (start) begin
            if (state == RUN) begin
                sb_v[0]  <= accept & of_valid;
                sb_wb[0] <= of_wb;
                sb_rd[0] <= of_rd;
                sb_v[1]  <= sb_v[0];
                sb_wb[1] <= sb_wb[0];
                sb_rd[1] <= sb_rd[0];
            end else begin
                sb_v[1]  <= 1'b0;
            end
            sb_v[2]  <= sb_v[1];
            sb_wb[2] <= sb_wb[1];
            sb_rd[2] <= sb_rd[1];
        end
    end

endmodule
